// File: rtl/registro_arranque_multicanal.sv
// Bank of N start/control registers written from the soft-processor output port.
// Each channel latches a command, goes busy, emits one start pulse and clears on listo.
module registro_arranque_multicanal #(
  parameter int         N         = 4,
  parameter int         WIDTH     = 8,
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter logic [7:0] CLR_ADDR  = 8'h1F,
  parameter bit         AUTO_CLR  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EN,
  input  logic                 W_Strobe,
  input  logic [7:0]           port_id,
  input  logic [7:0]           port_out,
  input  logic [N-1:0]         listo,
  output logic [N*WIDTH-1:0]   dato_salida,
  output logic [N-1:0]         arranque,
  output logic [N-1:0]         ocupado,
  output logic [N-1:0]         error_sobre
);

  logic               strobe_prev_q, strobe_prev_d;
  logic [N-1:0]       listo_prev_q, listo_prev_d;
  logic [N*WIDTH-1:0] dato_q, dato_d;
  logic [N-1:0]       ocupado_q, ocupado_d;
  logic [N-1:0]       ocupado_prev_q, ocupado_prev_d;
  logic [N-1:0]       arranque_q, arranque_d;
  logic [N-1:0]       error_q, error_d;

  logic               wr;
  logic [WIDTH-1:0]   wdata;
  logic               wdata_nz;
  logic [7:0]         chan_addr;
  logic               chan_hit;
  logic               listo_rise;

  always_comb begin
    strobe_prev_d  = W_Strobe;
    listo_prev_d   = listo;
    dato_d         = dato_q;
    ocupado_d      = ocupado_q;
    ocupado_prev_d = ocupado_q;
    error_d        = error_q;
    chan_addr      = 8'h00;
    chan_hit       = 1'b0;
    listo_rise     = 1'b0;

    // A strobe held high yields a single write on its rising edge only.
    wr       = EN & W_Strobe & ~strobe_prev_q;
    wdata    = port_out[WIDTH-1:0];
    wdata_nz = |wdata;

    // Clear first so a same-cycle error set below takes priority.
    if (wr && (port_id == CLR_ADDR)) begin
      error_d = '0;
    end

    for (int i = 0; i < N; i++) begin
      chan_addr  = BASE_ADDR + 8'(i);
      chan_hit   = wr && (port_id == chan_addr);
      listo_rise = listo[i] & ~listo_prev_q[i];
      if (chan_hit) begin
        dato_d[i*WIDTH +: WIDTH] = wdata;
        ocupado_d[i]             = wdata_nz;
        if (ocupado_q[i] && wdata_nz) begin
          error_d[i] = 1'b1;
        end
      end else if (listo_rise && ocupado_q[i]) begin
        ocupado_d[i] = 1'b0;
        if (AUTO_CLR) begin
          dato_d[i*WIDTH +: WIDTH] = '0;
        end
      end
    end

    // Start pulse lags the busy rise by one cycle.
    arranque_d = ocupado_q & ~ocupado_prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_prev_q  <= 1'b0;
      listo_prev_q   <= '0;
      dato_q         <= '0;
      ocupado_q      <= '0;
      ocupado_prev_q <= '0;
      arranque_q     <= '0;
      error_q        <= '0;
    end else begin
      strobe_prev_q  <= strobe_prev_d;
      listo_prev_q   <= listo_prev_d;
      dato_q         <= dato_d;
      ocupado_q      <= ocupado_d;
      ocupado_prev_q <= ocupado_prev_d;
      arranque_q     <= arranque_d;
      error_q        <= error_d;
    end
  end

  assign dato_salida = dato_q;
  assign arranque    = arranque_q;
  assign ocupado     = ocupado_q;
  assign error_sobre = error_q;

endmodule
